// File: rtl/fsm_vend_param.sv
// Parametrised vending controller: sums coins into credit, pulses sell at PRICE,
// and offers change or a cancel refund over a valid/ack handshake.
module fsm_vend_param #(
    parameter int unsigned CREDIT_W = 8,
    parameter int unsigned PRICE    = 3,
    parameter int unsigned COIN_A   = 1,
    parameter int unsigned COIN_B   = 2,
    parameter int unsigned COIN_C   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_a,
    input  logic                coin_b,
    input  logic                coin_c,
    input  logic                cancel,
    input  logic                change_ack,
    output logic                sell_flag,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                refund_flag,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [SUM_W-1:0]    coin_sum, sum, price_w;
    logic                any_coin;
    logic                sell_n, valid_n, refund_n, reject_n, busy_n;
    logic [CREDIT_W-1:0] amt_n, credit_n;

    // Coin value of this cycle and running total, one bit wider than credit
    always_comb begin
        coin_sum = (coin_a ? SUM_W'(COIN_A) : SUM_W'(0))
                 + (coin_b ? SUM_W'(COIN_B) : SUM_W'(0))
                 + (coin_c ? SUM_W'(COIN_C) : SUM_W'(0));
        sum      = SUM_W'(credit) + coin_sum;
        price_w  = SUM_W'(PRICE);
        any_coin = coin_a | coin_b | coin_c;
    end

    // Next state and next registered outputs
    always_comb begin
        state_n  = state;
        sell_n   = 1'b0;
        refund_n = 1'b0;
        reject_n = 1'b0;
        valid_n  = change_valid;
        amt_n    = change_amt;
        credit_n = credit;
        case (state)
            IDLE, ACCUM: begin
                if (cancel) begin
                    reject_n = any_coin;
                    if (credit != '0) begin
                        amt_n    = credit;
                        valid_n  = 1'b1;
                        refund_n = 1'b1;
                        credit_n = '0;
                        state_n  = CHANGE;
                    end
                end else if (sum >= price_w) begin
                    sell_n   = 1'b1;
                    credit_n = '0;
                    if (sum > price_w) begin
                        amt_n   = CREDIT_W'(sum - price_w);
                        valid_n = 1'b1;
                        state_n = CHANGE;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    credit_n = CREDIT_W'(sum);
                    state_n  = (sum != '0) ? ACCUM : IDLE;
                end
            end
            CHANGE: begin
                reject_n = any_coin;
                credit_n = '0;
                if (change_ack && change_valid) begin
                    valid_n = 1'b0;
                    amt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n  = IDLE;
                valid_n  = 1'b0;
                amt_n    = '0;
                credit_n = '0;
            end
        endcase
        busy_n = (state_n == CHANGE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            sell_flag    <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            refund_flag  <= 1'b0;
            coin_reject  <= 1'b0;
            credit       <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            sell_flag    <= sell_n;
            change_valid <= valid_n;
            change_amt   <= amt_n;
            refund_flag  <= refund_n;
            coin_reject  <= reject_n;
            credit       <= credit_n;
            busy         <= busy_n;
        end
    end

endmodule

// File: tb/tb_fsm_vend_param.sv
// Randomised bench for fsm_vend_param against a transaction-level vending model,
// plus directed sequences with hand-computed expectations.
module tb_fsm_vend_param;

    localparam int unsigned CW    = 8;
    localparam int          PRICE = 3;
    localparam int          CA    = 1;
    localparam int          CB    = 2;
    localparam int          CC    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          a, b, c, cancel, ack;
    logic          sell_flag, change_valid, refund_flag, coin_reject, busy;
    logic [CW-1:0] change_amt, credit;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Model: credit held, pending change amount, event pulses of last cycle
    int m_credit = 0;
    int m_amt    = 0;
    bit m_valid  = 1'b0;
    bit m_sell   = 1'b0;
    bit m_refund = 1'b0;
    bit m_reject = 1'b0;
    int m_paid, m_coins;

    fsm_vend_param #(
        .CREDIT_W(CW), .PRICE(PRICE), .COIN_A(CA), .COIN_B(CB), .COIN_C(CC)
    ) dut (
        .clk(clk), .rst(rst),
        .coin_a(a), .coin_b(b), .coin_c(c),
        .cancel(cancel), .change_ack(ack),
        .sell_flag(sell_flag), .change_valid(change_valid), .change_amt(change_amt),
        .refund_flag(refund_flag), .coin_reject(coin_reject),
        .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A pending change blocks the machine; otherwise coins buy or cancel refunds
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_credit = 0; m_amt = 0; m_valid = 0;
            m_sell = 0; m_refund = 0; m_reject = 0;
        end else begin
            m_coins  = CA * int'(a) + CB * int'(b) + CC * int'(c);
            m_sell   = 0;
            m_refund = 0;
            m_reject = 0;
            if (m_valid) begin
                m_reject = (m_coins != 0);
                if (ack) begin
                    m_valid = 0;
                    m_amt   = 0;
                end
            end else if (cancel) begin
                m_reject = (m_coins != 0);
                if (m_credit > 0) begin
                    m_amt    = m_credit;
                    m_valid  = 1;
                    m_refund = 1;
                    m_credit = 0;
                end
            end else begin
                m_paid = m_credit + m_coins;
                if (m_paid >= PRICE) begin
                    m_sell   = 1;
                    m_credit = 0;
                    if (m_paid > PRICE) begin
                        m_amt   = m_paid - PRICE;
                        m_valid = 1;
                    end
                end else begin
                    m_credit = m_paid;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("sell_flag",    int'(sell_flag),    int'(m_sell));
            chk("refund_flag",  int'(refund_flag),  int'(m_refund));
            chk("coin_reject",  int'(coin_reject),  int'(m_reject));
            chk("change_valid", int'(change_valid), int'(m_valid));
            chk("change_amt",   int'(change_amt),   m_amt);
            chk("credit",       int'(credit),       m_credit);
            chk("busy",         int'(busy),         int'(m_valid));
            chk("sell_and_refund", int'(sell_flag & refund_flag), 0);
        end
    end

    task automatic cyc(input bit ia, input bit ib, input bit ic, input bit ix, input bit ik);
        a = ia; b = ib; c = ic; cancel = ix; ack = ik;
        @(posedge clk);
        #1;
        a = 0; b = 0; c = 0; cancel = 0; ack = 0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_sell"},   int'(sell_flag),    0);
        chk({tag, "_valid"},  int'(change_valid), 0);
        chk({tag, "_amt"},    int'(change_amt),   0);
        chk({tag, "_refund"}, int'(refund_flag),  0);
        chk({tag, "_reject"}, int'(coin_reject),  0);
        chk({tag, "_credit"}, int'(credit),       0);
        chk({tag, "_busy"},   int'(busy),         0);
    endtask

    initial begin
        a = 0; b = 0; c = 0; cancel = 0; ack = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk); #1;
        all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Three half-yuan coins buy one item exactly
        cyc(1, 0, 0, 0, 0); chk("a1_credit", int'(credit), 1);
        cyc(1, 0, 0, 0, 0); chk("a2_credit", int'(credit), 2);
        cyc(1, 0, 0, 0, 0);
        chk("a3_sell", int'(sell_flag), 1);
        chk("a3_valid", int'(change_valid), 0);
        chk("a3_credit", int'(credit), 0);
        cyc(0, 0, 0, 0, 0); chk("a3_sell_drop", int'(sell_flag), 0);

        // Two one-yuan coins: sell with one unit of change
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("bb_sell", int'(sell_flag), 1);
        chk("bb_valid", int'(change_valid), 1);
        chk("bb_amt", int'(change_amt), 1);
        cyc(0, 0, 0, 0, 0); chk("bb_hold", int'(change_valid), 1);
        cyc(0, 0, 0, 0, 1);
        chk("bb_ack_valid", int'(change_valid), 0);
        chk("bb_ack_busy", int'(busy), 0);

        // Five-yuan coin, then a rejected coin while change pending
        cyc(0, 0, 1, 0, 0);
        chk("c_sell", int'(sell_flag), 1);
        chk("c_amt", int'(change_amt), 7);
        chk("c_busy", int'(busy), 1);
        cyc(1, 0, 0, 0, 0);
        chk("c_reject", int'(coin_reject), 1);
        chk("c_credit", int'(credit), 0);
        chk("c_amt_hold", int'(change_amt), 7);
        cyc(0, 0, 0, 1, 1);
        chk("c_reject_drop", int'(coin_reject), 0);
        chk("c_cancel_ignored", int'(refund_flag), 0);

        // Cancel refunds credit; cancel with no credit does nothing
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("cx_refund", int'(refund_flag), 1);
        chk("cx_amt", int'(change_amt), 1);
        chk("cx_sell", int'(sell_flag), 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        all_zero("cx_empty");

        // Simultaneous coins sum; cancel plus coin refunds and rejects
        cyc(1, 1, 0, 0, 0);
        chk("ab_sell", int'(sell_flag), 1);
        chk("ab_valid", int'(change_valid), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        chk("xb_refund", int'(refund_flag), 1);
        chk("xb_amt", int'(change_amt), 1);
        chk("xb_reject", int'(coin_reject), 1);
        chk("xb_credit", int'(credit), 0);
        cyc(0, 0, 0, 0, 1);

        // Asynchronous reset while change is pending
        cyc(0, 0, 1, 0, 0);
        chk("rst_pre_amt", int'(change_amt), 7);
        #2 rst = 1'b0;
        #1 all_zero("async_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0);
        chk("post_rst_credit", int'(credit), 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);

        // Random traffic, with occasional mid-cycle resets
        repeat (3000) begin
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                #5 rst = 1'b1;
            end
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
